// File: rtl/flash_pkg.sv
// Shared constants and types for the flash write-operation sequencer.
// Command codes, op encodings, status-register bits and FSM states.
package flash_pkg;

    localparam logic [3:0] CMD_WRITE_ENABLE     = 4'd0;
    localparam logic [3:0] CMD_SECTOR_ERASE_4KB = 4'd2;
    localparam logic [3:0] CMD_BLOCK_ERASE_64KB = 4'd3;
    localparam logic [3:0] CMD_CHIP_ERASE       = 4'd4;
    localparam logic [3:0] CMD_PROGRAM_PAGE     = 4'd5;
    localparam logic [3:0] CMD_READ_SR          = 4'd7;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [1:0] {
        OP_SECTOR_ERASE = 2'd0,
        OP_BLOCK_ERASE  = 2'd1,
        OP_CHIP_ERASE   = 2'd2,
        OP_PAGE_PROGRAM = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREN_ISSUE,
        ST_WREN_WAIT,
        ST_WEL_CHECK,
        ST_OP_ISSUE,
        ST_OP_WAIT,
        ST_POLL,
        ST_DONE
    } seq_state_t;

    typedef enum logic [2:0] {
        SR_IDLE,
        SR_ISSUE,
        SR_WAIT,
        SR_CAPTURE,
        SR_GAP
    } sr_state_t;

    function automatic logic [3:0] op_cmd(input op_t op);
        logic [3:0] c;
        c = CMD_SECTOR_ERASE_4KB;
        unique case (op)
            OP_SECTOR_ERASE: c = CMD_SECTOR_ERASE_4KB;
            OP_BLOCK_ERASE:  c = CMD_BLOCK_ERASE_64KB;
            OP_CHIP_ERASE:   c = CMD_CHIP_ERASE;
            OP_PAGE_PROGRAM: c = CMD_PROGRAM_PAGE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/flash_op_sequencer_if.sv
// Command bus between the sequencer (master) and the flash controller (slave).
interface flash_op_sequencer_if;

    logic        o_CMDEn;
    logic [3:0]  o_CMD;
    logic [23:0] o_Addr;
    logic        o_AckReq;
    logic        i_CMDBusy;
    logic [7:0]  i_ReadData;
    logic        i_NewDataAvailableNextClk;
    logic        i_ReqNextData;

    modport master (
        output o_CMDEn, o_CMD, o_Addr, o_AckReq,
        input  i_CMDBusy, i_ReadData,
        input  i_NewDataAvailableNextClk, i_ReqNextData
    );

    modport slave (
        input  o_CMDEn, o_CMD, o_Addr, o_AckReq,
        output i_CMDBusy, i_ReadData,
        output i_NewDataAvailableNextClk, i_ReqNextData
    );

endinterface

// File: rtl/flash_sr_poller.sv
// READ_SR issue/capture engine with inter-poll gap and saturating poll count.
// i_Single requests exactly one read regardless of WIP.
module flash_sr_poller
    import flash_pkg::*;
#(
    parameter int POLL_GAP  = 16,
    parameter int MAX_POLLS = 65535
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Start,
    input  logic       i_Single,
    input  logic       i_CMDBusy,
    input  logic [7:0] i_ReadData,
    input  logic       i_NewDataAvailableNextClk,
    output logic       o_CMDEn,
    output logic       o_AckReq,
    output logic       o_Active,
    output logic       o_Done,
    output logic       o_Timeout,
    output logic [7:0] o_Status
);

    localparam int CW = $clog2(MAX_POLLS + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_POLLS);
    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

    sr_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    gap_q, gap_d;
    logic [7:0]    status_q, status_d;
    logic          single_q, single_d;
    logic          done_q, done_d;
    logic          tout_q, tout_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        status_d = status_q;
        single_d = single_q;
        done_d   = 1'b0;
        tout_d   = tout_q;
        unique case (state_q)
            SR_IDLE: begin
                if (i_Start) begin
                    cnt_d    = '0;
                    single_d = i_Single;
                    tout_d   = 1'b0;
                    state_d  = SR_ISSUE;
                end
            end
            SR_ISSUE: begin
                if (!i_CMDBusy) state_d = SR_WAIT;
            end
            SR_WAIT: begin
                if (i_NewDataAvailableNextClk) state_d = SR_CAPTURE;
            end
            SR_CAPTURE: begin
                status_d = i_ReadData;
                cnt_d = (cnt_q == MAXC) ? cnt_q : cnt_q + 1'b1;
                if (single_q || !i_ReadData[SR_WIP]) begin
                    done_d  = 1'b1;
                    state_d = SR_IDLE;
                end else if (cnt_d == MAXC) begin
                    done_d  = 1'b1;
                    tout_d  = 1'b1;
                    state_d = SR_IDLE;
                end else begin
                    gap_d   = '0;
                    state_d = SR_GAP;
                end
            end
            SR_GAP: begin
                if (gap_q == GAP_LAST) state_d = SR_ISSUE;
                else gap_d = gap_q + 8'd1;
            end
            default: state_d = SR_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q  <= SR_IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            status_q <= '0;
            single_q <= 1'b0;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            status_q <= status_d;
            single_q <= single_d;
            done_q   <= done_d;
            tout_q   <= tout_d;
        end
    end

    assign o_CMDEn   = (state_q == SR_ISSUE) && !i_CMDBusy;
    assign o_AckReq  = (state_q == SR_ISSUE) || (state_q == SR_WAIT);
    assign o_Active  = (state_q != SR_IDLE);
    assign o_Done    = done_q;
    assign o_Timeout = tout_q;
    assign o_Status  = status_q;

endmodule

// File: rtl/flash_op_sequencer.sv
// WREN -> erase/program -> READ_SR polling sequencer for the flash controller.
// FLASH_SEQ_VERIFY_WEL_EN adds a WEL check read between WREN and the op.
module flash_op_sequencer
    import flash_pkg::*;
#(
    parameter int POLL_GAP  = 16,
    parameter int MAX_POLLS = 65535
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Start,
    input  logic [1:0]  i_Op,
    input  logic [23:0] i_Addr,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Error,
    output logic        o_ReqNextData,
    input  logic        i_UpAckReq,
    flash_op_sequencer_if.master ctrl
);

    seq_state_t  state_q, state_d;
    op_t         op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [3:0]  cmd_q, cmd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        prog_q, prog_d;
    logic        first_q, first_d;
    logic        pstart_q, pstart_d;
    logic        psingle_q, psingle_d;

    logic        p_cmd_en, p_ack, p_active;
    logic        p_done, p_timeout;
    logic [7:0]  p_status;
    logic        seq_en;
    logic        unused_status;

    flash_sr_poller #(
        .POLL_GAP  (POLL_GAP),
        .MAX_POLLS (MAX_POLLS)
    ) u_poller (
        .i_Clk                     (i_Clk),
        .i_Rst                     (i_Rst),
        .i_Start                   (pstart_q),
        .i_Single                  (psingle_q),
        .i_CMDBusy                 (ctrl.i_CMDBusy),
        .i_ReadData                (ctrl.i_ReadData),
        .i_NewDataAvailableNextClk (ctrl.i_NewDataAvailableNextClk),
        .o_CMDEn                   (p_cmd_en),
        .o_AckReq                  (p_ack),
        .o_Active                  (p_active),
        .o_Done                    (p_done),
        .o_Timeout                 (p_timeout),
        .o_Status                  (p_status)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        cmd_d     = cmd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        prog_d    = prog_q;
        first_d   = first_q;
        pstart_d  = 1'b0;
        psingle_d = psingle_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    op_d    = op_t'(i_Op);
                    addr_d  = i_Addr;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    cmd_d   = CMD_WRITE_ENABLE;
                    state_d = ST_WREN_ISSUE;
                end
            end
            ST_WREN_ISSUE: begin
                if (!ctrl.i_CMDBusy) begin
                    first_d = 1'b1;
                    state_d = ST_WREN_WAIT;
                end
            end
            ST_WREN_WAIT: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!ctrl.i_CMDBusy) begin
`ifdef FLASH_SEQ_VERIFY_WEL_EN
                    pstart_d  = 1'b1;
                    psingle_d = 1'b1;
                    state_d   = ST_WEL_CHECK;
`else
                    cmd_d   = op_cmd(op_q);
                    state_d = ST_OP_ISSUE;
`endif
                end
            end
`ifdef FLASH_SEQ_VERIFY_WEL_EN
            ST_WEL_CHECK: begin
                if (p_done) begin
                    if (!p_status[SR_WEL]) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cmd_d   = op_cmd(op_q);
                        state_d = ST_OP_ISSUE;
                    end
                end
            end
`endif
            ST_OP_ISSUE: begin
                if (!ctrl.i_CMDBusy) begin
                    prog_d  = (op_q == OP_PAGE_PROGRAM);
                    first_d = 1'b1;
                    state_d = ST_OP_WAIT;
                end
            end
            ST_OP_WAIT: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!ctrl.i_CMDBusy) begin
                    prog_d    = 1'b0;
                    pstart_d  = 1'b1;
                    psingle_d = 1'b0;
                    state_d   = ST_POLL;
                end
            end
            ST_POLL: begin
                if (p_done) begin
                    done_d  = 1'b1;
                    err_d   = p_timeout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_SECTOR_ERASE;
            addr_q    <= '0;
            cmd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            prog_q    <= 1'b0;
            first_q   <= 1'b0;
            pstart_q  <= 1'b0;
            psingle_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            cmd_q     <= cmd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            prog_q    <= prog_d;
            first_q   <= first_d;
            pstart_q  <= pstart_d;
            psingle_q <= psingle_d;
        end
    end

`ifdef FLASH_SEQ_VERIFY_WEL_EN
    assign unused_status = ^{p_status[7:2], p_status[SR_WIP]};
`else
    assign unused_status = ^p_status;
`endif

    // Strobe gated combinationally so an idle controller sees it 1 cycle after start.
    assign seq_en = ((state_q == ST_WREN_ISSUE) || (state_q == ST_OP_ISSUE))
                    && !ctrl.i_CMDBusy;

    assign ctrl.o_CMDEn   = seq_en | p_cmd_en;
    assign ctrl.o_CMD     = p_active ? CMD_READ_SR : cmd_q;
    assign ctrl.o_Addr    = addr_q;
    assign ctrl.o_AckReq  = prog_q ? i_UpAckReq : p_ack;
    assign o_ReqNextData  = prog_q & ctrl.i_ReqNextData;
    assign o_Busy         = busy_q;
    assign o_Done         = done_q;
    assign o_Error        = err_q;

endmodule
